// File: rtl/velocity_update_stage_if.sv
// Cache/control bundle between a velocity update stage and its cell caches.
interface velocity_update_stage_if;
    logic        ready;
    logic        double_buffer;
    logic        done;
    logic [31:0] raddr;
    logic [96:0] r_f;
    logic [96:0] r_v;
    logic [31:0] waddr;
    logic [96:0] w_v;
    logic        v_we;
    logic        f_we;
    logic [31:0] faddr;

    modport master (
        input  ready, double_buffer, r_f, r_v,
        output done, raddr, waddr, w_v, v_we, f_we, faddr
    );

    modport slave (
        output ready, double_buffer, r_f, r_v,
        input  done, raddr, waddr, w_v, v_we, f_we, faddr
    );
endinterface

// File: rtl/velocity_update_stage.sv
// Per-cell velocity integrator: streams force/velocity caches, writes v + (f >>> DT_SHIFT)
// into the opposite velocity bank, clears each force entry and raises done.
module velocity_update_stage #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned DT_SHIFT = 8
) (
    input logic                     clk,
    input logic                     reset,
    velocity_update_stage_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic          bank;
    logic [CW-1:0] iss;
    logic [IW-1:0] a_idx;
    logic [IW-1:0] d_idx;
    logic          a_vld;
    logic          d_vld;
    logic [AW-1:0] rb;
    logic [AW-1:0] wb;
    logic          term;
    logic [96:0]   upd;
    logic          unused_f_valid;

    // One saturating Q16.16 component update
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [31:0] f);
        logic signed [31:0] fs;
        logic [32:0]        sum;
        fs  = $signed(f) >>> DT_SHIFT;
        sum = {v[31], v} + {fs[31], fs};
        if (sum[32] != sum[31])
            sat_add = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            sat_add = sum[31:0];
    endfunction

    assign unused_f_valid = bus.r_f[96];

    always_comb begin
        rb   = bank ? AW'(DEPTH) : '0;
        wb   = bank ? '0 : AW'(DEPTH);
        term = d_vld && !bus.r_v[96];
        upd  = {1'b1,
                sat_add(bus.r_v[95:64], bus.r_f[95:64]),
                sat_add(bus.r_v[63:32], bus.r_f[63:32]),
                sat_add(bus.r_v[31:0],  bus.r_f[31:0])};
    end

    // a_vld: a read address is on raddr this cycle; d_vld: its data is on r_v/r_f this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bank      <= 1'b0;
            iss       <= '0;
            a_idx     <= '0;
            d_idx     <= '0;
            a_vld     <= 1'b0;
            d_vld     <= 1'b0;
            bus.done  <= 1'b0;
            bus.raddr <= '0;
            bus.waddr <= '0;
            bus.faddr <= '0;
            bus.w_v   <= '0;
            bus.v_we  <= 1'b0;
            bus.f_we  <= 1'b0;
        end else begin
            bus.v_we <= 1'b0;
            bus.f_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.ready && !bus.done) begin
                        bank      <= bus.double_buffer;
                        bus.raddr <= bus.double_buffer ? AW'(DEPTH) : '0;
                        a_idx     <= '0;
                        a_vld     <= 1'b1;
                        d_vld     <= 1'b0;
                        iss       <= CW'(1);
                        state     <= (DEPTH == 1) ? DRAIN : RUN;
                    end
                end
                RUN, DRAIN: begin
                    d_vld <= a_vld;
                    d_idx <= a_idx;
                    if (d_vld) begin
                        bus.v_we  <= 1'b1;
                        bus.waddr <= wb + AW'(d_idx);
                        bus.w_v   <= term ? '0 : upd;
                        bus.f_we  <= !term;
                        if (!term)
                            bus.faddr <= rb + AW'(d_idx);
                    end
                    // Terminator: drop every read still in flight
                    if (term) begin
                        a_vld <= 1'b0;
                        d_vld <= 1'b0;
                        state <= DRAIN;
                    end else if (state == RUN) begin
                        bus.raddr <= rb + AW'(iss);
                        a_idx     <= IW'(iss);
                        a_vld     <= 1'b1;
                        iss       <= iss + CW'(1);
                        if (iss == CW'(DEPTH - 1))
                            state <= DRAIN;
                    end else begin
                        a_vld <= 1'b0;
                        if (!a_vld && !d_vld) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.ready) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_velocity_update_stage.sv
// Randomized bench for velocity_update_stage with a cache model and an arithmetic reference.
module tb_velocity_update_stage;
    localparam int unsigned DEPTH    = 256;
    localparam int unsigned DT_SHIFT = 8;
    localparam longint      SMAX     = 64'sd2147483647;
    localparam longint      SMIN     = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] addr;
        logic [96:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = -1;
    int   done_hi = 0;

    logic [96:0] v_mem [0:2*DEPTH-1];
    logic [96:0] f_mem [0:2*DEPTH-1];
    wr_t         got_w[$];
    wr_t         exp_w[$];
    logic [31:0] got_f[$];
    logic [31:0] exp_f[$];

    velocity_update_stage_if bus();

    velocity_update_stage #(.DEPTH(DEPTH), .DT_SHIFT(DT_SHIFT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Cache model: one-cycle synchronous read
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        bus.r_v <= v_mem[bus.raddr[8:0]];
        bus.r_f <= f_mem[bus.raddr[8:0]];
    end

    always @(negedge clk) begin
        if (bus.v_we) got_w.push_back({bus.waddr, bus.w_v});
        if (bus.f_we) got_f.push_back(bus.faddr);
        if (bus.done) begin
            done_hi++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    end

    function automatic logic [31:0] ref_comp(input logic [31:0] v, input logic [31:0] f);
        longint s;
        s = longint'(int'(v)) + longint'(int'(f) >>> DT_SHIFT);
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return 32'(s);
    endfunction

    task automatic fill_cell(input logic db, input int nvalid);
        int rb;
        rb = db ? int'(DEPTH) : 0;
        for (int a = 0; a < 2 * int'(DEPTH); a++) begin
            v_mem[a] = {1'b0, $urandom, $urandom, $urandom};
            f_mem[a] = {1'($urandom), $urandom, $urandom, $urandom};
        end
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (k < nvalid) v_mem[rb + k][96] = 1'b1;
            else if (k > nvalid) v_mem[rb + k][96] = 1'($urandom);
        end
    endtask

    // Reference: walk slots until the first invalid velocity or the end of the bank
    task automatic build_expected(input logic db);
        int rb;
        int wb;
        logic [96:0] v;
        logic [96:0] f;
        rb = db ? int'(DEPTH) : 0;
        wb = db ? 0 : int'(DEPTH);
        exp_w.delete();
        exp_f.delete();
        for (int k = 0; k < int'(DEPTH); k++) begin
            v = v_mem[rb + k];
            f = f_mem[rb + k];
            if (!v[96]) begin
                exp_w.push_back({32'(wb + k), 97'b0});
                break;
            end
            exp_w.push_back({32'(wb + k), 1'b1, ref_comp(v[95:64], f[95:64]),
                             ref_comp(v[63:32], f[63:32]), ref_comp(v[31:0], f[31:0])});
            exp_f.push_back(32'(rb + k));
        end
    endtask

    task automatic run_phase(input logic db, input int drop_at, output int lat, output bit to);
        int c0;
        int n;
        got_w.delete();
        got_f.delete();
        done_cyc = -1;
        done_hi  = 0;
        @(negedge clk);
        bus.double_buffer = db;
        bus.ready = 1'b1;
        c0 = cyc;
        n = 0;
        while (done_cyc < 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == drop_at) bus.ready = 1'b0;
        end
        to  = (done_cyc < 0);
        lat = done_cyc - c0 - 1;
        bus.ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        bus.ready = 1'b1;
        bus.double_buffer = 1'b0;
        fill_cell(1'b0, 5);
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.done, bus.v_we, bus.f_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got done/v_we/f_we=%b exp 000", {bus.done, bus.v_we, bus.f_we});
        end
        checks++;
        if (bus.raddr !== 0 || bus.waddr !== 0 || bus.faddr !== 0 || bus.w_v !== 0) begin
            errors++;
            $display("FAIL reset_bus got raddr=%h waddr=%h faddr=%h w_v=%h exp all 0",
                     bus.raddr, bus.waddr, bus.faddr, bus.w_v);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.raddr !== 32'd0 || bus.v_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_raddr got raddr=%h v_we=%b exp 0/0", bus.raddr, bus.v_we);
        end
        @(negedge clk);
        checks++;
        if (bus.raddr !== 32'd1) begin
            errors++;
            $display("FAIL reset_second_raddr got %h exp 1", bus.raddr);
        end
        n = 0;
        while (!bus.done && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!bus.done) begin
            errors++;
            $display("FAIL reset_release_done got done=%b exp 1", bus.done);
        end
        bus.ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_three();
        int lat;
        bit to;
        fill_cell(1'b0, 3);
        v_mem[0] = {1'b1, 32'h0001_0000, 32'h0, 32'h0};
        f_mem[0] = {1'b0, 32'h0002_0000, 32'h0, 32'h0};
        build_expected(1'b0);
        run_phase(1'b0, 0, lat, to);
        checks++;
        if (to || lat != 6) begin
            errors++;
            $display("FAIL three_done_lat got %0d (timeout %0d) exp 6", lat, to);
        end
        checks++;
        if (got_w.size() != 4 || got_w[0].addr !== 32'd256 || got_w[0].data[95:64] !== 32'h0001_0200) begin
            errors++;
            $display("FAIL three_first_write got n=%0d w0=%h exp n=4 addr=256 x=00010200",
                     got_w.size(), got_w.size() > 0 ? got_w[0] : '0);
        end
        checks++;
        if (got_w.size() != 4 || got_w[3] !== {32'd259, 97'b0}) begin
            errors++;
            $display("FAIL three_terminator got n=%0d exp terminator 0 at 259", got_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL three_write%0d got %h exp %h", i, got_w[i], exp_w[i]);
            end
        end
        checks++;
        if (got_f.size() != 3 || got_f[0] !== 0 || got_f[1] !== 1 || got_f[2] !== 2) begin
            errors++;
            $display("FAIL three_fclear got n=%0d exp addrs 0,1,2", got_f.size());
        end
    endtask

    task automatic test_saturation();
        int lat;
        bit to;
        fill_cell(1'b0, 1);
        v_mem[0] = {1'b1, 32'h7FFF_FF00, 32'h8000_0000, 32'h0000_0010};
        f_mem[0] = {1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_F000};
        run_phase(1'b0, 0, lat, to);
        checks++;
        if (got_w.size() != 2 || got_w[0].data !== {1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000}) begin
            errors++;
            $display("FAIL sat_value got n=%0d w0=%h exp 1_7fffffff_80000000_00000000",
                     got_w.size(), got_w.size() > 0 ? got_w[0].data : '0);
        end
    endtask

    task automatic test_empty();
        int lat;
        bit to;
        fill_cell(1'b0, 0);
        run_phase(1'b0, 0, lat, to);
        checks++;
        if (to || lat != 3) begin
            errors++;
            $display("FAIL empty_done_lat got %0d (timeout %0d) exp 3", lat, to);
        end
        checks++;
        if (got_w.size() != 1 || got_w[0] !== {32'd256, 97'b0} || got_f.size() != 0) begin
            errors++;
            $display("FAIL empty_writes got nw=%0d nf=%0d exp single 0 at 256, no clears",
                     got_w.size(), got_f.size());
        end
    endtask

    task automatic test_full();
        int lat;
        bit to;
        int bad;
        fill_cell(1'b1, DEPTH);
        build_expected(1'b1);
        run_phase(1'b1, 0, lat, to);
        checks++;
        if (to || lat != int'(DEPTH) + 2) begin
            errors++;
            $display("FAIL full_done_lat got %0d (timeout %0d) exp %0d", lat, to, DEPTH + 2);
        end
        checks++;
        if (got_w.size() != int'(DEPTH) || got_f.size() != int'(DEPTH)) begin
            errors++;
            $display("FAIL full_counts got nw=%0d nf=%0d exp %0d each", got_w.size(), got_f.size(), DEPTH);
        end
        bad = 0;
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            if (got_w[i] !== exp_w[i] || got_f[i] !== exp_f[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_contents got %0d wrong entries exp 0", bad);
        end
    endtask

    task automatic test_ready_drop();
        int lat;
        bit to;
        fill_cell(1'b1, 10);
        build_expected(1'b1);
        run_phase(1'b1, 3, lat, to);
        checks++;
        if (to || lat != 13 || done_hi != 1) begin
            errors++;
            $display("FAIL drop_done got lat=%0d hi_cycles=%0d exp lat=13 hi_cycles=1", lat, done_hi);
        end
        checks++;
        if (got_w.size() != exp_w.size() || got_f.size() != exp_f.size()) begin
            errors++;
            $display("FAIL drop_counts got nw=%0d nf=%0d exp %0d/%0d",
                     got_w.size(), got_f.size(), exp_w.size(), exp_f.size());
        end
    endtask

    task automatic test_random();
        int lat;
        bit to;
        logic db;
        int nv;
        for (int it = 0; it < 6; it++) begin
            db = 1'($urandom);
            nv = (it == 5) ? int'(DEPTH) : int'($urandom_range(0, 40));
            fill_cell(db, nv);
            build_expected(db);
            run_phase(db, 0, lat, to);
            checks++;
            if (to || lat != exp_w.size() + 2 || got_w.size() != exp_w.size() || got_f.size() != exp_f.size()) begin
                errors++;
                $display("FAIL rand%0d_shape got lat=%0d nw=%0d nf=%0d exp lat=%0d nw=%0d nf=%0d",
                         it, lat, got_w.size(), got_f.size(), exp_w.size() + 2, exp_w.size(), exp_f.size());
            end
            for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
                checks++;
                if (got_w[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d got %h exp %h", it, i, got_w[i], exp_w[i]);
                end
            end
            for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
                checks++;
                if (got_f[i] !== exp_f[i]) begin
                    errors++;
                    $display("FAIL rand%0d_fclear%0d got %h exp %h", it, i, got_f[i], exp_f[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit to;
        fill_cell(1'b0, DEPTH);
        @(negedge clk);
        bus.double_buffer = 1'b0;
        bus.ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.raddr !== 32'd5 || bus.v_we !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre got raddr=%h v_we=%b exp 5/1", bus.raddr, bus.v_we);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.v_we !== 1'b0 || bus.f_we !== 1'b0 || bus.raddr !== 0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got v_we=%b f_we=%b raddr=%h done=%b exp 0",
                     bus.v_we, bus.f_we, bus.raddr, bus.done);
        end
        bus.ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        fill_cell(1'b0, 7);
        build_expected(1'b0);
        run_phase(1'b0, 0, lat, to);
        checks++;
        if (to || lat != 10 || got_w.size() != exp_w.size()) begin
            errors++;
            $display("FAIL rerun_shape got lat=%0d nw=%0d exp lat=10 nw=%0d", lat, got_w.size(), exp_w.size());
        end
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL rerun_write%0d got %h exp %h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.ready = 1'b0;
        bus.double_buffer = 1'b0;
        test_reset();
        test_three();
        test_saturation();
        test_empty();
        test_full();
        test_ready_drop();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/velocity_update_stage.md
Name: velocity_update_stage

Overview:
- Per-cell velocity integrator that runs immediately upstream of the position-update phase.
- It streams one cell's force-accumulator cache and velocity cache and writes v' = v + (f >>> DT_SHIFT) into the opposite velocity bank.
- It clears each force entry after reading it and reports done, so the position-update phase can consume the fresh velocities.
- One instance per cell; the top level instantiates N_CELL copies.

Parameters:
- DEPTH, 256, maximum entries per cell cache bank; power of two.
- DT_SHIFT, 8, arithmetic right shift applied to force (dt/m scaling, Q16.16).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- ready  input  1  level start; phase runs while high.
- double_buffer  input  1  bank select: read bank = double_buffer, write bank = ~double_buffer.
- done  output  1  phase complete; held until ready falls.
- raddr  output  32  shared read address into force and velocity caches.
- r_f  input  97  force entry: [96] valid, [95:64] fx, [63:32] fy, [31:0] fz; signed Q16.16.
- r_v  input  97  velocity entry, same format.
- waddr  output  32  write address into the velocity cache.
- w_v  output  97  updated velocity entry.
- v_we  output  1  velocity write enable.
- f_we  output  1  force-cache clear enable; uses raddr_d2 as its address.
- faddr  output  32  force clear address.

Behaviour:
- Reset values, in effect asynchronously while reset=0: done=0, raddr=0, waddr=0, faddr=0, w_v=0, v_we=0, f_we=0, state=IDLE, counters=0.
- Caches have 1-cycle synchronous read latency.
- Bank base addresses: read base RB = double_buffer ? DEPTH : 0; write base WB = double_buffer ? 0 : DEPTH.
- double_buffer is sampled on the IDLE->RUN transition and held for the whole phase.
- IDLE: when ready=1 and done=0, latch the bank, set raddr=RB, idx=0, go to RUN.
- RUN: issue raddr=RB+idx each cycle and increment idx.
  - Entry issued at cycle t has data at t+1, is registered by the compute stage at t+1, and is written at t+2.
  - Throughput is 1 entry per cycle.
- Termination of issue:
  - Issue stops when idx reaches DEPTH, or when data returns with r_v[96]=0 (terminator).
  - On the terminator, any reads already issued are discarded: no writes for them.
  - Go to DRAIN.
- DRAIN: finish outstanding valid writes, then go to DONE.
- DONE: done=1 while ready=1. When ready falls: done=0, go to IDLE on the next cycle.
- Per valid entry (r_v[96]=1), for each component:
  - sum = sext33(v) + sext33(f >>> DT_SHIFT).
  - Saturate to [0x80000000, 0x7FFFFFFF].
  - w_v = {1'b1, x', y', z'}, waddr = WB+k, v_we=1.
  - f_we=1, faddr = RB+k, force data implied zero.
- Force valid bit r_f[96] is ignored; a missing force is treated as zero by the producer.
- Terminator entry (first r_v[96]=0 at slot k < DEPTH):
  - Write w_v=97'b0 at WB+k with v_we=1, so the downstream sees the end of the cell.
  - f_we=0 for that slot.
- Full cell (DEPTH valid entries): no terminator is written.
- v_we and f_we are single-cycle pulses per entry; both are 0 in IDLE and DONE.
- ready falling mid-RUN/DRAIN is ignored; the phase completes, then done pulses for one cycle and returns to IDLE.
- reset asserted mid-operation: immediate return to reset values; no partial write is completed.

Test Plan:
- Reset: hold reset=0 with ready=1 and random cache data -> all outputs 0. Release -> first raddr=0 (double_buffer=0) on the next cycle.
- 3-particle cell, double_buffer=0, DT_SHIFT=8:
  - Stimulus: v0=(0x00010000,0,0), f0=(0x00020000,0,0); slot 3 invalid.
  - Required: writes at addresses 256..259; w_v@256 x=0x00010200; terminator 0 written at 259; f_we at 0..2 only; done asserted at cycle 6 after start.
- Saturation: v.x=0x7FFFFF00, f.x=0x7FFFFFFF -> w_v.x=0x7FFFFFFF. v.y=0x80000000, f.y=0x80000000 -> w_v.y=0x80000000.
- Empty cell: slot 0 invalid -> a single write of 0 to WB, no f_we, done at cycle 3 after start.
- Bank swap and full cell: double_buffer=1 with all DEPTH entries valid -> reads at 256..511, writes at 0..255, no terminator, done after DEPTH+2 cycles.
- Reset mid-RUN at idx=5 -> v_we drops the same cycle. Rerun with ready=1 -> restarts from RB with correct results.
